// File: rtl/backend_pkg.sv
// backend_pkg: shared widths, lane/bypass defaults and packet types for the register-read stage.
package backend_pkg;
  localparam int DEF_NUM_LANES = 2;
  localparam int DEF_NUM_FWD   = 3;
  localparam int PREG_W        = 6;
  localparam int XLEN          = 32;

  typedef enum logic {REG_FILE = 1'b0, FORWARD = 1'b1} fwrd_mux;

  typedef struct packed {
    logic              instr_valid;
    logic [XLEN-1:0]   pc;
    logic [PREG_W-1:0] dst_preg;
    logic [PREG_W-1:0] src1_preg;
    logic [PREG_W-1:0] src2_preg;
    logic [XLEN-1:0]   imm_val;
  } disp_packet_t;

  typedef struct packed {
    logic              instr_valid;
    logic [XLEN-1:0]   pc;
    logic [PREG_W-1:0] dst_preg;
    logic [PREG_W-1:0] src1_preg;
    logic [PREG_W-1:0] src2_preg;
    logic [XLEN-1:0]   imm_val;
    logic [XLEN-1:0]   src1_val;
    logic [XLEN-1:0]   src2_val;
    fwrd_mux           src1_sel;
    fwrd_mux           src2_sel;
  } exec_packet_t;
endpackage

// File: rtl/reg_read_stage_nw_if.sv
// reg_read_stage_nw_if: scheduler-side and execute-side group handshakes of the register-read stage.
interface reg_read_stage_nw_if #(
  parameter int NUM_LANES = backend_pkg::DEF_NUM_LANES
);
  logic [NUM_LANES-1:0]                      in_valid;
  backend_pkg::disp_packet_t [NUM_LANES-1:0] in_pkt;
  logic                                      in_ready;
  logic [NUM_LANES-1:0]                      out_valid;
  backend_pkg::exec_packet_t [NUM_LANES-1:0] out_pkt;
  logic                                      out_ready;

  modport master (output in_valid, in_pkt, out_ready, input in_ready, out_valid, out_pkt);
  modport slave  (input in_valid, in_pkt, out_ready, output in_ready, out_valid, out_pkt);
endinterface

// File: rtl/fwd_operand_sel.sv
// fwd_operand_sel: picks one operand from the RF or the highest-priority matching bypass source.
module fwd_operand_sel import backend_pkg::*; #(
  parameter int NUM_FWD = DEF_NUM_FWD
) (
  input  logic [PREG_W-1:0]              src_i,
  input  logic [XLEN-1:0]                rf_val_i,
  input  logic [NUM_FWD-1:0]             fwd_valid_i,
  input  logic [NUM_FWD-1:0][PREG_W-1:0] fwd_preg_i,
  input  logic [NUM_FWD-1:0][XLEN-1:0]   fwd_val_i,
  output logic [XLEN-1:0]                val_o,
  output logic                           hit_o
);
  // Scan oldest to youngest so the lowest matching index is written last; preg 0 is hardwired zero.
  always_comb begin
    val_o = rf_val_i;
    hit_o = 1'b0;
    for (int f = NUM_FWD - 1; f >= 0; f--) begin
      if (fwd_valid_i[f] && fwd_preg_i[f] == src_i) begin
        val_o = fwd_val_i[f];
        hit_o = 1'b1;
      end
    end
    if (src_i == '0) begin
      val_o = '0;
      hit_o = 1'b0;
    end
  end
endmodule

// File: rtl/reg_read_stage_nw.sv
// reg_read_stage_nw: N-lane register-read stage with bypass select, output register and 1-entry skid.
// Optional performance counters are built when REG_READ_PERF_EN is defined.
module reg_read_stage_nw import backend_pkg::*; #(
  parameter int NUM_LANES = DEF_NUM_LANES,
  parameter int NUM_FWD   = DEF_NUM_FWD
) (
  input  logic                                clk,
  input  logic                                rst_n,
  reg_read_stage_nw_if.slave                  bus,
  output logic [NUM_LANES-1:0][PREG_W-1:0]    rf_src1_reg,
  output logic [NUM_LANES-1:0][PREG_W-1:0]    rf_src2_reg,
  input  logic [NUM_LANES-1:0][XLEN-1:0]      rf_src1_val,
  input  logic [NUM_LANES-1:0][XLEN-1:0]      rf_src2_val,
  input  logic [NUM_FWD-1:0]                  fwd_valid,
  input  logic [NUM_FWD-1:0][PREG_W-1:0]      fwd_preg,
  input  logic [NUM_FWD-1:0][XLEN-1:0]        fwd_val,
  input  logic                                flush
`ifdef REG_READ_PERF_EN
  ,
  output logic [31:0]                         perf_stall_cyc,
  output logic [31:0]                         perf_fwd_hits
`endif
);
  exec_packet_t [NUM_LANES-1:0] res, out_pkt_q, out_pkt_d, skid_pkt_q, skid_pkt_d;
  logic [NUM_LANES-1:0] out_vld_q, out_vld_d, skid_vld_q, skid_vld_d, hit1, hit2;
  logic present, accept, skid_valid, out_free;

  assign present       = |bus.in_valid;
  assign skid_valid    = |skid_vld_q;
  assign bus.in_ready  = !skid_valid && !flush;
  assign accept        = present && bus.in_ready;
  assign out_free      = !(|out_vld_q) || bus.out_ready;
  assign bus.out_valid = out_vld_q;
  assign bus.out_pkt   = out_pkt_q;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [XLEN-1:0] v1, v2;
    assign rf_src1_reg[l] = bus.in_pkt[l].src1_preg;
    assign rf_src2_reg[l] = bus.in_pkt[l].src2_preg;
    fwd_operand_sel #(.NUM_FWD(NUM_FWD)) u_src1 (
      .src_i       (bus.in_pkt[l].src1_preg),
      .rf_val_i    (rf_src1_val[l]),
      .fwd_valid_i (fwd_valid),
      .fwd_preg_i  (fwd_preg),
      .fwd_val_i   (fwd_val),
      .val_o       (v1),
      .hit_o       (hit1[l])
    );
    fwd_operand_sel #(.NUM_FWD(NUM_FWD)) u_src2 (
      .src_i       (bus.in_pkt[l].src2_preg),
      .rf_val_i    (rf_src2_val[l]),
      .fwd_valid_i (fwd_valid),
      .fwd_preg_i  (fwd_preg),
      .fwd_val_i   (fwd_val),
      .val_o       (v2),
      .hit_o       (hit2[l])
    );
    assign res[l] = '{
      instr_valid: bus.in_pkt[l].instr_valid,
      pc:          bus.in_pkt[l].pc,
      dst_preg:    bus.in_pkt[l].dst_preg,
      src1_preg:   bus.in_pkt[l].src1_preg,
      src2_preg:   bus.in_pkt[l].src2_preg,
      imm_val:     bus.in_pkt[l].imm_val,
      src1_val:    v1,
      src2_val:    v2,
      src1_sel:    hit1[l] ? FORWARD : REG_FILE,
      src2_sel:    hit2[l] ? FORWARD : REG_FILE
    };
  end

  // Flush kills everything; a free output takes the skid first, else the accepted group; a held output parks the accepted group in the skid.
  always_comb begin
    out_vld_d  = out_vld_q;
    out_pkt_d  = out_pkt_q;
    skid_vld_d = skid_vld_q;
    skid_pkt_d = skid_pkt_q;
    if (flush) begin
      out_vld_d  = '0;
      skid_vld_d = '0;
    end else if (out_free) begin
      out_vld_d  = skid_valid ? skid_vld_q : accept ? bus.in_valid : '0;
      out_pkt_d  = skid_valid ? skid_pkt_q : accept ? res : out_pkt_q;
      skid_vld_d = '0;
    end else if (accept) begin
      skid_vld_d = bus.in_valid;
      skid_pkt_d = res;
    end
  end

  // Output and skid registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q  <= '0;
      out_pkt_q  <= '0;
      skid_vld_q <= '0;
      skid_pkt_q <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_pkt_q  <= out_pkt_d;
      skid_vld_q <= skid_vld_d;
      skid_pkt_q <= skid_pkt_d;
    end
  end

`ifdef REG_READ_PERF_EN
  logic [31:0] stall_q, stall_d, hits_q, hits_d, hit_cnt;
  logic [32:0] hits_sum;

  // Stalled-cycle and forwarded-operand counts, both saturating.
  always_comb begin
    hit_cnt = '0;
    for (int i = 0; i < NUM_LANES; i++)
      hit_cnt = hit_cnt + 32'(hit1[i] & bus.in_valid[i]) + 32'(hit2[i] & bus.in_valid[i]);
    hits_sum = {1'b0, hits_q} + {1'b0, accept ? hit_cnt : 32'd0};
    hits_d   = hits_sum[32] ? '1 : hits_sum[31:0];
    stall_d  = (present && !bus.in_ready && stall_q != '1) ? stall_q + 32'd1 : stall_q;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      hits_q  <= '0;
    end else begin
      stall_q <= stall_d;
      hits_q  <= hits_d;
    end
  end

  assign perf_stall_cyc = stall_q;
  assign perf_fwd_hits  = hits_q;
`endif
endmodule

// File: tb/tb_reg_read_stage_nw.sv
// tb_reg_read_stage_nw: scoreboard bench for the register-read stage.
module tb_reg_read_stage_nw;
  import backend_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  reg_read_stage_nw_if #(.NUM_LANES(2)) bus ();
  logic [1:0][5:0]  rf_src1_reg, rf_src2_reg;
  logic [1:0][31:0] rf_src1_val, rf_src2_val;
  logic [2:0]       fwd_valid;
  logic [2:0][5:0]  fwd_preg;
  logic [2:0][31:0] fwd_val;
  logic [15:0]      rf_salt = 16'h0;
`ifdef REG_READ_PERF_EN
  logic [31:0] perf_stall_cyc, perf_fwd_hits;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [1:0]         vld;
    exec_packet_t [1:0] pkt;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  reg_read_stage_nw #(.NUM_LANES(2), .NUM_FWD(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .rf_src1_reg (rf_src1_reg),
    .rf_src2_reg (rf_src2_reg),
    .rf_src1_val (rf_src1_val),
    .rf_src2_val (rf_src2_val),
    .fwd_valid   (fwd_valid),
    .fwd_preg    (fwd_preg),
    .fwd_val     (fwd_val),
    .flush       (flush)
`ifdef REG_READ_PERF_EN
    ,
    .perf_stall_cyc (perf_stall_cyc),
    .perf_fwd_hits  (perf_fwd_hits)
`endif
  );

  function automatic logic [31:0] rf_fn(logic [15:0] s, logic [5:0] p);
    return (p == 6'd0) ? 32'hDEAD : {s, 10'd0, p};
  endfunction

  always_comb begin
    for (int l = 0; l < 2; l++) begin
      rf_src1_val[l] = rf_fn(rf_salt, rf_src1_reg[l]);
      rf_src2_val[l] = rf_fn(rf_salt, rf_src2_reg[l]);
    end
  end

  function automatic logic [32:0] opnd(logic [5:0] s);
    if (s == 6'd0) return 33'd0;
    for (int f = 0; f < 3; f++)
      if (fwd_valid[f] && fwd_preg[f] == s) return {1'b1, fwd_val[f]};
    return {1'b0, rf_fn(rf_salt, s)};
  endfunction

  function automatic exec_packet_t model(disp_packet_t p);
    logic [32:0] a, b;
    exec_packet_t e;
    a = opnd(p.src1_preg);
    b = opnd(p.src2_preg);
    e.instr_valid = p.instr_valid;
    e.pc          = p.pc;
    e.dst_preg    = p.dst_preg;
    e.src1_preg   = p.src1_preg;
    e.src2_preg   = p.src2_preg;
    e.imm_val     = p.imm_val;
    e.src1_val    = a[31:0];
    e.src2_val    = b[31:0];
    e.src1_sel    = a[32] ? FORWARD : REG_FILE;
    e.src2_sel    = b[32] ? FORWARD : REG_FILE;
    return e;
  endfunction

  function automatic disp_packet_t mk(logic [31:0] pc, logic [5:0] s1, logic [5:0] s2, logic [5:0] d);
    disp_packet_t p;
    p.instr_valid = 1'b1;
    p.pc          = pc;
    p.dst_preg    = d;
    p.src1_preg   = s1;
    p.src2_preg   = s2;
    p.imm_val     = pc ^ 32'h5A5A_0000;
    return p;
  endfunction

  // Scoreboard: pop on each delivered group, push the model result on each accepted group.
  always @(negedge clk) begin
    if (!rst_n) begin
    end else if (flush) begin
      sb.delete();
    end else begin
      if (|bus.out_valid && bus.out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got vld=%b pkt=%h, required no output", bus.out_valid, bus.out_pkt);
        end else begin
          mon_e = sb.pop_front();
          if ({bus.out_valid, bus.out_pkt} !== mon_e) begin
            errors++;
            $display("FAIL sb_out: got vld=%b pkt=%h, required vld=%b pkt=%h",
                     bus.out_valid, bus.out_pkt, mon_e.vld, mon_e.pkt);
          end
        end
      end
      if (|bus.in_valid && bus.in_ready)
        sb.push_back({bus.in_valid, model(bus.in_pkt[1]), model(bus.in_pkt[0])});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    bus.in_valid = '0;
    bus.in_pkt = '0;
    bus.out_ready = 1'b1;
    fwd_valid = '0;
    fwd_preg = '0;
    fwd_val = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.out_valid !== 2'b00 || bus.in_ready !== 1'b1 || bus.out_pkt !== '0) begin
      errors++;
      $display("FAIL reset_state: got vld=%b rdy=%b pkt=%h, required vld=00 rdy=1 pkt=0", bus.out_valid, bus.in_ready, bus.out_pkt);
    end
`ifdef REG_READ_PERF_EN
    checks++;
    if (perf_stall_cyc !== 32'd0 || perf_fwd_hits !== 32'd0) begin
      errors++;
      $display("FAIL reset_perf: got stall=%0d hits=%0d, required 0 0", perf_stall_cyc, perf_fwd_hits);
    end
`endif
    cyc();
    rst_n = 1'b1;
    bus.out_ready = 1'b0;
    bus.in_pkt[0] = mk(32'h40, 6'd1, 6'd2, 6'd3);
    bus.in_pkt[1] = mk(32'h44, 6'd4, 6'd5, 6'd6);
    bus.in_valid = 2'b11;
    cyc();
    bus.in_valid = '0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 2'b11) begin
      errors++;
      $display("FAIL pre_reset_valid: got %b, required 11", bus.out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 2'b00 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_async: got vld=%b rdy=%b, required vld=00 rdy=1", bus.out_valid, bus.in_ready);
    end
    sb.delete();
    cyc();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
  endtask

  task automatic test_fwd_priority();
    bus.in_pkt[0] = mk(32'h100, 6'd5, 6'd9, 6'd1);
    bus.in_pkt[1] = mk(32'h104, 6'd6, 6'd5, 6'd2);
    fwd_valid = 3'b110;
    fwd_preg[0] = 6'd5;
    fwd_preg[1] = 6'd5;
    fwd_preg[2] = 6'd5;
    fwd_val[0] = 32'h0BAD_0000;
    fwd_val[1] = 32'h1111_AAAA;
    fwd_val[2] = 32'h2222_BBBB;
    bus.in_valid = 2'b11;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL fwd_in_ready: got %b, required 1", bus.in_ready);
    end
    cyc();
    bus.in_valid = '0;
    fwd_valid = '0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 2'b11 || bus.out_pkt[0].src1_val !== 32'h1111_AAAA || bus.out_pkt[1].src2_val !== 32'h1111_AAAA) begin
      errors++;
      $display("FAIL fwd_priority: got vld=%b l0s1=%h l1s2=%h, required vld=11 l0s1=1111aaaa l1s2=1111aaaa",
               bus.out_valid, bus.out_pkt[0].src1_val, bus.out_pkt[1].src2_val);
    end
  endtask

  task automatic test_zero_preg();
    cyc();
    bus.in_pkt[0] = mk(32'h200, 6'd0, 6'd0, 6'd3);
    bus.in_pkt[1] = mk(32'h204, 6'd7, 6'd0, 6'd4);
    fwd_valid = 3'b001;
    fwd_preg[0] = 6'd0;
    fwd_val[0] = 32'h1234_5678;
    bus.in_valid = 2'b11;
    cyc();
    bus.in_valid = '0;
    fwd_valid = '0;
    @(negedge clk);
    checks++;
    if (bus.out_pkt[0].src1_val !== 32'd0 || bus.out_pkt[0].src1_sel !== REG_FILE) begin
      errors++;
      $display("FAIL zero_preg: got val=%h sel=%b, required val=0 sel=0", bus.out_pkt[0].src1_val, bus.out_pkt[0].src1_sel);
    end
  endtask

  task automatic test_partial_idle();
    cyc();
    bus.in_pkt[0] = mk(32'h300, 6'd8, 6'd9, 6'd5);
    bus.in_pkt[1] = mk(32'h304, 6'd10, 6'd11, 6'd6);
    bus.in_valid = 2'b01;
    cyc();
    bus.in_valid = '0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 2'b01) begin
      errors++;
      $display("FAIL partial_lane: got %b, required 01", bus.out_valid);
    end
    cyc();
    bus.in_pkt[0] = mk(32'h310, 6'd12, 6'd13, 6'd7);
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 2'b00) begin
      errors++;
      $display("FAIL idle_bubble: got %b, required 00", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    cyc();
    bus.out_ready = 1'b0;
    rf_salt = 16'h1111;
    fwd_valid = 3'b001;
    fwd_preg[0] = 6'd20;
    fwd_val[0] = 32'hF00D_0001;
    bus.in_pkt[0] = mk(32'h400, 6'd20, 6'd21, 6'd1);
    bus.in_pkt[1] = mk(32'h404, 6'd22, 6'd20, 6'd2);
    bus.in_valid = 2'b11;
    cyc();
    rf_salt = 16'h2222;
    fwd_val[0] = 32'hF00D_0002;
    bus.in_pkt[0] = mk(32'h408, 6'd20, 6'd23, 6'd3);
    bus.in_pkt[1] = mk(32'h40C, 6'd24, 6'd25, 6'd4);
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 2'b11) begin
      errors++;
      $display("FAIL b2b_second_accept: got rdy=%b vld=%b, required rdy=1 vld=11", bus.in_ready, bus.out_valid);
    end
    cyc();
    rf_salt = 16'h3333;
    fwd_val[0] = 32'hF00D_0003;
    bus.in_pkt[0] = mk(32'h410, 6'd20, 6'd26, 6'd5);
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_skid_full: got rdy=%b, required 0", bus.in_ready);
    end
    cyc();
    bus.in_valid = '0;
    bus.out_ready = 1'b1;
    rf_salt = 16'h4444;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_pkt[0].pc !== 32'h400) begin
      errors++;
      $display("FAIL b2b_drain1: got rdy=%b pc=%h, required rdy=0 pc=400", bus.in_ready, bus.out_pkt[0].pc);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_pkt[0].pc !== 32'h408 || bus.out_pkt[0].src1_val !== 32'hF00D_0002) begin
      errors++;
      $display("FAIL b2b_drain2: got rdy=%b pc=%h s1=%h, required rdy=1 pc=408 s1=f00d0002",
               bus.in_ready, bus.out_pkt[0].pc, bus.out_pkt[0].src1_val);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 2'b00 || sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_empty: got vld=%b pending=%0d, required vld=00 pending=0", bus.out_valid, sb.size());
    end
    fwd_valid = '0;
  endtask

  task automatic test_flush();
    cyc();
    bus.out_ready = 1'b0;
    bus.in_pkt[0] = mk(32'h500, 6'd1, 6'd2, 6'd3);
    bus.in_pkt[1] = mk(32'h504, 6'd4, 6'd5, 6'd6);
    bus.in_valid = 2'b11;
    cyc();
    bus.in_pkt[0] = mk(32'h508, 6'd7, 6'd8, 6'd9);
    cyc();
    bus.in_pkt[0] = mk(32'h50C, 6'd10, 6'd11, 6'd12);
    flush = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_in_ready: got %b, required 0", bus.in_ready);
    end
    cyc();
    flush = 1'b0;
    bus.in_valid = '0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 2'b00 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_clear: got vld=%b rdy=%b, required vld=00 rdy=1", bus.out_valid, bus.in_ready);
    end
    cyc();
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 2'b00) begin
      errors++;
      $display("FAIL flush_dropped: got vld=%b, required 00", bus.out_valid);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      cyc();
      bus.in_valid = 2'($urandom_range(0, 3));
      for (int l = 0; l < 2; l++)
        bus.in_pkt[l] = mk($urandom, 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)), 6'($urandom_range(0, 63)));
      for (int f = 0; f < 3; f++) begin
        fwd_preg[f] = 6'($urandom_range(0, 7));
        fwd_val[f] = $urandom;
      end
      fwd_valid = 3'($urandom_range(0, 7));
      rf_salt = 16'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 31) == 0);
    end
    cyc();
    bus.in_valid = '0;
    flush = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0 || bus.out_valid !== 2'b00) begin
      errors++;
      $display("FAIL random_drain: got pending=%0d vld=%b, required pending=0 vld=00", sb.size(), bus.out_valid);
    end
  endtask

`ifdef REG_READ_PERF_EN
  task automatic test_perf();
    cyc();
    rst_n = 1'b0;
    sb.delete();
    cyc();
    rst_n = 1'b1;
    bus.out_ready = 1'b0;
    bus.in_pkt[0] = mk(32'h600, 6'd3, 6'd4, 6'd1);
    bus.in_pkt[1] = mk(32'h604, 6'd3, 6'd10, 6'd2);
    fwd_valid = 3'b011;
    fwd_preg[0] = 6'd3;
    fwd_preg[1] = 6'd4;
    fwd_preg[2] = 6'd0;
    bus.in_valid = 2'b11;
    cyc();
    fwd_valid = '0;
    bus.in_pkt[0] = mk(32'h608, 6'd3, 6'd4, 6'd5);
    cyc();
    bus.in_pkt[0] = mk(32'h60C, 6'd3, 6'd4, 6'd6);
    repeat (4) cyc();
    bus.in_valid = '0;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (perf_stall_cyc !== 32'd4 || perf_fwd_hits !== 32'd3) begin
      errors++;
      $display("FAIL perf_counts: got stall=%0d hits=%0d, required stall=4 hits=3", perf_stall_cyc, perf_fwd_hits);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fwd_priority();
    test_zero_preg();
    test_partial_idle();
    test_back_to_back();
    test_flush();
    test_random();
`ifdef REG_READ_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
